// File: rtl/systolic_pkg.sv
// Shared constants and types for the 4x4 systolic matrix-multiply engine.
//   N           : matrix dimension (PE grid is N x N)
//   DATA_W      : operand / accumulator width
//   ADDR_W      : result-memory address width
//   LOAD_LEN    : operand bytes per job (A then B, row-major)
//   COMPUTE_LEN : cycles spent streaming operands through the grid
//   RES_CNT     : result elements written per job
package systolic_pkg;

  localparam int unsigned N           = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned LOAD_LEN    = 2 * N * N;
  localparam int unsigned COMPUTE_LEN = 3 * N - 1;
  localparam int unsigned RES_CNT     = N * N;
  localparam int unsigned CNT_W       = $clog2(LOAD_LEN);
  localparam int unsigned RES_W       = $clog2(RES_CNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the systolic grid.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of accumulator and pass-through registers
//   a_in, b_in : operands arriving from the left / from above
//   a_out      : a_in registered, forwarded to the right neighbour
//   b_out      : b_in registered, forwarded to the neighbour below
//   acc        : running sum of a_in*b_in, truncated to DATA_W bits
module systolic_pe
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a_in * b_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/systolic_array.sv
// 4x4 matrix-multiply engine: loads A and B from a byte stream, multiplies
// them on an N x N systolic PE grid, then writes the 16 products to a
// result memory one per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : rising edge while idle begins a job
//   in_data    : operand byte, one per cycle during LOAD
//   sum_out    : result element written to memory
//   ws         : result-memory write address (RESULT_BASE + index, wraps)
//   we         : result-memory write enable
//   sys_finish : one-cycle pulse when the job completes
module systolic_array
  import systolic_pkg::*;
#(
  parameter int unsigned N           = systolic_pkg::N,
  parameter logic [13:0] RESULT_BASE = 14'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  output logic [7:0]  sum_out,
  output logic [13:0] ws,
  output logic        we,
  output logic        sys_finish
);

  state_t            state, state_nxt;
  logic              start_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_buf [LOAD_LEN];
  logic [DATA_W-1:0] a_feed [N];
  logic [DATA_W-1:0] b_feed [N];
  logic [DATA_W-1:0] a_link [N][N+1];
  logic [DATA_W-1:0] b_link [N+1][N];
  logic [DATA_W-1:0] c_mat  [RES_CNT];
  logic              load_last, compute_last, write_last;

  assign load_last    = (state == S_LOAD)    && (cnt == CNT_W'(LOAD_LEN - 1));
  assign compute_last = (state == S_COMPUTE) && (cnt == CNT_W'(COMPUTE_LEN - 1));
  assign write_last   = (state == S_WRITE)   && (cnt == CNT_W'(RES_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && !start_q) state_nxt = S_LOAD;
      S_LOAD:    if (load_last)         state_nxt = S_COMPUTE;
      S_COMPUTE: if (compute_last)      state_nxt = S_WRITE;
      S_WRITE:   if (write_last)        state_nxt = S_DONE;
      S_DONE:                           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // One counter serves as byte index, compute step and result index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sum_out    <= '0;
      ws         <= '0;
      we         <= 1'b0;
      sys_finish <= 1'b0;
      for (int unsigned i = 0; i < LOAD_LEN; i++) op_buf[i] <= '0;
    end else begin
      we         <= 1'b0;
      sys_finish <= (state == S_DONE);
      if (state_nxt != state)
        cnt <= '0;
      else if (state inside {S_LOAD, S_COMPUTE, S_WRITE})
        cnt <= cnt + 1'b1;
      if (state == S_LOAD)
        op_buf[cnt] <= in_data;
      if (state == S_WRITE) begin
        we      <= 1'b1;
        ws      <= RESULT_BASE + ADDR_W'(cnt);
        sum_out <= c_mat[cnt[RES_W-1:0]];
      end
    end
  end

  // Skew feeders: at compute step t, row i presents A[i][t-i] and column j
  // presents B[t-j][j]; both meet in PE(i,j) at step k+i+j for the same k.
  always_comb begin
    int unsigned t;
    int unsigned k;
    t = 32'(cnt);
    k = 0;
    for (int unsigned i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
      if (state == S_COMPUTE && t >= i && t < i + N) begin
        k         = t - i;
        a_feed[i] = op_buf[CNT_W'(i * N + k)];
        b_feed[i] = op_buf[CNT_W'(N * N + k * N + i)];
      end
    end
  end

  // Accumulators clear on the edge that enters COMPUTE.
  for (genvar r = 0; r < N; r++) begin : g_row
    assign a_link[r][0] = a_feed[r];
    assign b_link[0][r] = b_feed[r];
    for (genvar c = 0; c < N; c++) begin : g_col
      systolic_pe u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_last),
        .a_in  (a_link[r][c]),
        .b_in  (b_link[r][c]),
        .a_out (a_link[r][c+1]),
        .b_out (b_link[r+1][c]),
        .acc   (c_mat[r*N+c])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic [7:0]  sum_out;
  logic [13:0] ws;
  logic        we;
  logic        sys_finish;

  int total = 0;
  int bad   = 0;

  logic [7:0] bytes_q [32];
  logic [7:0] exp_c   [16];

  systolic_array #(.N(4), .RESULT_BASE(14'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .sum_out    (sum_out),
    .ws         (ws),
    .we         (we),
    .sys_finish (sys_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int n = 0; n < 32; n++) begin
      case (pat)
        0:       bytes_q[n] = 8'd1;
        1:       bytes_q[n] = (n < 16) ? (((n / 4) == (n % 4)) ? 8'd1 : 8'd0) : 8'(n - 15);
        2:       bytes_q[n] = 8'hFF;
        default: bytes_q[n] = 8'($urandom);
      endcase
    end
    // C[i][j] = sum_k A[i][k]*B[k][j] mod 256
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'(bytes_q[4*i+k]) * int'(bytes_q[16+4*k+j]);
        exp_c[4*i+j] = 8'(s % 256);
      end
  endtask

  // abort_at: cycle offset after T at which reset is asserted (0 = none)
  task automatic run_job(input int pat, input bit hold_start, input bit toggle, input int abort_at);
    fill(pat);
    @(negedge clk); start = 1'b1;
    @(negedge clk);                      // edge T has sampled the rise
    for (int n = 0; n < 32; n++) begin
      in_data = bytes_q[n];
      @(negedge clk);                    // edge T+1+n captured byte n
    end
    if (!hold_start) start = 1'b0;
    in_data = 8'($urandom);
    for (int e = 33; e <= 43; e++) begin
      if (toggle) start = e[0];
      @(negedge clk);
      check($sformatf("p%0d_we_compute_%0d", pat, e), 32'(we), 32'd0);
    end
    if (toggle) start = 1'b0;
    for (int idx = 0; idx < 16; idx++) begin
      @(negedge clk);                    // after edge T+44+idx
      if (abort_at == 44 + idx) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("p%0d_abort_we", pat), 32'(we), 32'd0);
        check($sformatf("p%0d_abort_ws", pat), 32'(ws), 32'd0);
        check($sformatf("p%0d_abort_sum", pat), 32'(sum_out), 32'd0);
        check($sformatf("p%0d_abort_fin", pat), 32'(sys_finish), 32'd0);
        return;
      end
      check($sformatf("p%0d_we_%0d", pat, idx), 32'(we), 32'd1);
      check($sformatf("p%0d_ws_%0d", pat, idx), 32'(ws), 32'(idx));
      check($sformatf("p%0d_sum_%0d", pat, idx), 32'(sum_out), 32'(exp_c[idx]));
      check($sformatf("p%0d_fin_w%0d", pat, idx), 32'(sys_finish), 32'd0);
    end
    @(negedge clk);                      // after edge T+60
    check($sformatf("p%0d_finish", pat), 32'(sys_finish), 32'd1);
    check($sformatf("p%0d_we_done", pat), 32'(we), 32'd0);
    check($sformatf("p%0d_ws_hold", pat), 32'(ws), 32'd15);
    check($sformatf("p%0d_sum_hold", pat), 32'(sum_out), 32'(exp_c[15]));
    @(negedge clk);                      // after edge T+61
    check($sformatf("p%0d_finish_end", pat), 32'(sys_finish), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n   = 1'b0;
    start   = 1'b0;
    in_data = 8'd0;
    #23;
    check("rst_we", 32'(we), 32'd0);
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_fin", 32'(sys_finish), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_job(0, 1'b0, 1'b0, 0);           // all ones -> every C = 4
    run_job(1, 1'b0, 1'b0, 0);           // identity * (1..16)
    run_job(2, 1'b0, 1'b0, 0);           // all 0xFF -> wrap to 4

    run_job(3, 1'b1, 1'b0, 0);           // start stays high afterwards
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      seen += int'(we) + int'(sys_finish);
    end
    check("held_start_no_job", 32'(seen), 32'd0);
    @(negedge clk); start = 1'b0;
    run_job(4, 1'b0, 1'b0, 0);           // fresh edge, same timing

    run_job(5, 1'b0, 1'b1, 0);           // start toggled during COMPUTE

    run_job(6, 1'b0, 1'b0, 50);          // reset mid-WRITE
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      seen += int'(we) + int'(sys_finish);
    end
    check("after_abort_quiet", 32'(seen), 32'd0);

    for (int p = 7; p < 10; p++) run_job(p, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
